// File: rtl/mul_pipe.sv
// Pipelined WA x WB multiplier with per-operation signed/unsigned mode.
// Supports stall (freeze), flush (discard in-flight work) and async reset.
module mul_pipe #(
  parameter int WA     = 24,
  parameter int WB     = 24,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_signed,
  input  logic [WA-1:0]      opa,
  input  logic [WB-1:0]      opb,
  input  logic               stall,
  input  logic               flush,
  output logic               in_ready,
  output logic [WA+WB-1:0]   prod,
  output logic               out_valid,
  output logic               busy
);

  localparam int PW = WA + WB;

  // Extending both operands to the full product width makes the low PW bits
  // of the product exact in either mode, so no wider intermediate is needed.
  function automatic logic signed [PW-1:0] mul_full(input logic [WA-1:0] a,
                                                     input logic [WB-1:0] b,
                                                     input logic          sgn);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    ax = sgn ? PW'($signed(a)) : PW'(a);
    bx = sgn ? PW'($signed(b)) : PW'(b);
    return ax * bx;
  endfunction

  logic          src_vld;
  logic          src_sgn;
  logic [WA-1:0] src_a;
  logic [WB-1:0] src_b;
  logic          pipe_busy_nxt;
  logic          out_nxt;
  logic          ld_prod;

  assign in_ready = !stall;

  generate
    if (STAGES == 1) begin : g_direct
      assign src_vld       = in_valid;
      assign src_sgn       = in_signed;
      assign src_a         = opa;
      assign src_b         = opb;
      assign pipe_busy_nxt = 1'b0;
    end else begin : g_pipe
      localparam int IS = STAGES - 1;

      logic [IS-1:0] vld_p;
      logic [IS-1:0] vld_nxt;
      logic [IS-1:0] sgn_p;
      logic [WA-1:0] opa_p [IS];
      logic [WB-1:0] opb_p [IS];

      always_comb begin
        vld_nxt = vld_p;
        if (flush) begin
          vld_nxt = '0;
        end else if (!stall) begin
          vld_nxt[0] = in_valid;
          for (int i = 1; i < IS; i++) vld_nxt[i] = vld_p[i-1];
        end
      end

      // Operand stages p0..p(IS-1): mode bit travels with its operands.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p <= '0;
          sgn_p <= '0;
          for (int i = 0; i < IS; i++) begin
            opa_p[i] <= '0;
            opb_p[i] <= '0;
          end
        end else begin
          vld_p <= vld_nxt;
          if (!stall) begin
            opa_p[0] <= opa;
            opb_p[0] <= opb;
            sgn_p[0] <= in_signed;
            for (int i = 1; i < IS; i++) begin
              opa_p[i] <= opa_p[i-1];
              opb_p[i] <= opb_p[i-1];
              sgn_p[i] <= sgn_p[i-1];
            end
          end
        end
      end

      assign src_vld       = vld_p[IS-1];
      assign src_sgn       = sgn_p[IS-1];
      assign src_a         = opa_p[IS-1];
      assign src_b         = opb_p[IS-1];
      assign pipe_busy_nxt = |vld_nxt;
    end
  endgenerate

  always_comb begin
    out_nxt = out_valid;
    if (flush)       out_nxt = 1'b0;
    else if (!stall) out_nxt = src_vld;
  end

  assign ld_prod = !stall && !flush && src_vld;

  // Output stage: multiply and register; prod keeps its value between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= out_nxt;
      busy      <= out_nxt | pipe_busy_nxt;
      if (ld_prod) prod <= mul_full(src_a, src_b, src_sgn);
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: three configurations share one stimulus stream and are
// compared every cycle against a slot-history reference model.
module tb_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_signed;
  logic [23:0] opa;
  logic [23:0] opb;
  logic        stall;
  logic        flush;

  logic        rdy0, rdy1, rdy2;
  logic [47:0] prod0, prod1;
  logic [23:0] prod2;
  logic        ov0, ov1, ov2;
  logic        busy0, busy1, busy2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_pipe #(.WA(24), .WB(24), .STAGES(2)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_signed(in_signed),
    .opa(opa), .opb(opb), .stall(stall), .flush(flush),
    .in_ready(rdy0), .prod(prod0), .out_valid(ov0), .busy(busy0));

  mul_pipe #(.WA(24), .WB(24), .STAGES(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_signed(in_signed),
    .opa(opa), .opb(opb), .stall(stall), .flush(flush),
    .in_ready(rdy1), .prod(prod1), .out_valid(ov1), .busy(busy1));

  mul_pipe #(.WA(8), .WB(16), .STAGES(4)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_signed(in_signed),
    .opa(opa[7:0]), .opb(opb[15:0]), .stall(stall), .flush(flush),
    .in_ready(rdy2), .prod(prod2), .out_valid(ov2), .busy(busy2));

  // Reference model: every advancing edge n owns a slot holding what was
  // offered on it. A configuration with latency S shows slot n-S+1 after
  // edge n; slots at or below 'kill' were discarded by flush or reset.
  localparam int HN = 8192;
  int          cfg_s  [3] = '{2, 1, 4};
  int          cfg_wa [3] = '{24, 24, 8};
  int          cfg_wb [3] = '{24, 24, 16};
  bit          hv [HN];
  logic [23:0] ha [HN];
  logic [23:0] hb [HN];
  bit          hs [HN];
  int          n    = 0;
  int          kill = 0;
  logic [47:0] ep   [3];
  bit          eov  [3];
  bit          ebusy[3];

  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b,
                                          input int wa, input int wb, input bit sgn);
    longint av, bv, p;
    av = longint'(a) & ((longint'(1) << wa) - 1);
    bv = longint'(b) & ((longint'(1) << wb) - 1);
    if (sgn && av >= (longint'(1) << (wa - 1))) av -= (longint'(1) << wa);
    if (sgn && bv >= (longint'(1) << (wb - 1))) bv -= (longint'(1) << wb);
    p = (av * bv) & ((longint'(1) << (wa + wb)) - 1);
    return p[47:0];
  endfunction

  task automatic model_reset();
    kill = n;
    for (int k = 0; k < 3; k++) begin
      ep[k] = '0; eov[k] = 0; ebusy[k] = 0;
    end
  endtask

  task automatic model_edge();
    int m;
    if (flush) begin
      if (!stall) begin n++; hv[n] = 0; end
      kill = n;
      for (int k = 0; k < 3; k++) begin eov[k] = 0; ebusy[k] = 0; end
    end else if (!stall) begin
      n++;
      hv[n] = in_valid; ha[n] = opa; hb[n] = opb; hs[n] = in_signed;
      for (int k = 0; k < 3; k++) begin
        m = n - cfg_s[k] + 1;
        eov[k] = (m > kill) && hv[m];
        if (eov[k]) ep[k] = ref_mul(ha[m], hb[m], cfg_wa[k], cfg_wb[k], hs[m]);
        ebusy[k] = eov[k];
        for (int j = m + 1; j <= n; j++)
          if (j > kill && hv[j]) ebusy[k] = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("d0_prod", prod0, ep[0]);
    chk("d1_prod", prod1, ep[1]);
    chk("d2_prod", {24'b0, prod2}, ep[2]);
    chk("d0_ov", 48'(ov0), 48'(eov[0]));
    chk("d1_ov", 48'(ov1), 48'(eov[1]));
    chk("d2_ov", 48'(ov2), 48'(eov[2]));
    chk("d0_busy", 48'(busy0), 48'(ebusy[0]));
    chk("d1_busy", 48'(busy1), 48'(ebusy[1]));
    chk("d2_busy", 48'(busy2), 48'(ebusy[2]));
    chk("in_ready", {45'b0, rdy0, rdy1, rdy2}, {45'b0, {3{~stall}}});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_prod_now", prod0, 48'h0);
    chk("rst_ov_now", 48'(ov0), 48'h0);
    chk("rst_busy_now", 48'(busy0), 48'h0);
    compare_all();
  endtask

  task automatic drive(input bit v, input bit s, input logic [23:0] a, input logic [23:0] b);
    in_valid = v; in_signed = s; opa = a; opb = b;
  endtask

  function automatic logic [23:0] pick();
    case ($urandom_range(0, 6))
      0:       return 24'h000000;
      1:       return 24'hFFFFFF;
      2:       return 24'h800000;
      3:       return 24'h7FFFFF;
      4:       return {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, $urandom_range(0, 1) ? 8'h80 : 8'h7F};
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [47:0] held;
    rst = 1'b1; stall = 0; flush = 0;
    drive(0, 0, 24'h0, 24'h0);
    model_reset();

    chk("model_umax", ref_mul(24'hFFFFFF, 24'hFFFFFF, 24, 24, 0), 48'hFFFFFE000001);
    chk("model_sneg", ref_mul(24'hFFFFFF, 24'h000002, 24, 24, 1), 48'hFFFFFFFFFFFE);
    chk("model_smin", ref_mul(24'h800000, 24'h800000, 24, 24, 1), 48'h400000000000);
    chk("model_8x16", ref_mul(24'h000080, 24'h008000, 8, 16, 1), 48'h000000400000);

    #1;
    compare_all();
    chk("reset_prod", prod0, 48'h0);
    step(); step();
    rst = 1'b0;
    step();

    // Unsigned maximum operands.
    drive(1, 0, 24'hFFFFFF, 24'hFFFFFF);
    step();
    drive(0, 0, 24'h0, 24'h0);
    step();
    chk("umax_prod", prod0, 48'hFFFFFE000001);
    chk("umax_ov", 48'(ov0), 48'h1);
    step();
    chk("umax_ov_once", 48'(ov0), 48'h0);

    // Signed, back to back.
    drive(1, 1, 24'hFFFFFF, 24'h000002);
    step();
    drive(1, 1, 24'h800000, 24'h800000);
    step();
    chk("sneg_prod", prod0, 48'hFFFFFFFFFFFE);
    drive(0, 0, 24'h0, 24'h0);
    step();
    chk("smin_prod", prod0, 48'h400000000000);
    chk("smin_ov", 48'(ov0), 48'h1);

    // Stall for three edges after accepting 3x5.
    drive(1, 0, 24'd3, 24'd5);
    step();
    drive(0, 0, 24'h0, 24'h0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ov", 48'(ov0), 48'h0);
      chk("stall_prod", prod0, 48'h400000000000);
      chk("stall_rdy", 48'(rdy0), 48'h0);
    end
    stall = 0;
    step();
    chk("stall_res", prod0, 48'd15);
    chk("stall_res_ov", 48'(ov0), 48'h1);
    step();

    // Four back-to-back ops, then flush together with stall.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 24'(i), 24'd100);
      step();
    end
    held = prod0;
    stall = 1; flush = 1; in_valid = 1;
    step();
    chk("flush_ov", 48'(ov0), 48'h0);
    chk("flush_busy", 48'(busy0), 48'h0);
    chk("flush_prod", prod0, held);
    stall = 0; flush = 0;
    drive(0, 0, 24'h0, 24'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_after_ov", 48'(ov0), 48'h0);
    end

    // Asynchronous reset while 7x9 is in flight.
    drive(1, 0, 24'd7, 24'd9);
    step();
    drive(0, 0, 24'h0, 24'h0);
    async_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_no_result", prod0, 48'h0);
    end

    // Randomized traffic with stall, flush and occasional reset.
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pick(), pick());
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
